// File: rtl/opponent_attack_gen_if.sv
// opponent_attack_gen_if: attack valid/ready handshake between the generator and the control FSM
interface opponent_attack_gen_if #(parameter int MOVE_BITS = 2);
    logic                 move_valid;
    logic                 move_ready;
    logic [MOVE_BITS-1:0] move_code;
    modport master (output move_valid, move_code, input move_ready);
    modport slave (input move_valid, move_code, output move_ready);
endinterface

// File: rtl/opponent_attack_gen.sv
// opponent_attack_gen: turns LFSR bits into a move code plus random wind-up, then offers the attack
// Optional ATTACK_GEN_NO_REPEAT_EN bumps a code that repeats the last accepted one.
module opponent_attack_gen #(
    parameter int MOVE_BITS  = 2,
    parameter int DELAY_BITS = 4,
    parameter int BASE_DELAY = 8,
    parameter int COOLDOWN   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic random_bit,
    input  logic stun,
    output logic lfsr_enable,
    output logic telegraph,
    opponent_attack_gen_if.master bus
);
    localparam int TOTAL = MOVE_BITS + DELAY_BITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int KW    = $clog2(COOLDOWN + 1);

    typedef enum logic [2:0] {IDLE, GATHER, WAIT, ISSUE, COOL} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TOTAL-1:0]     shift_q, shift_d;
    logic [7:0]           timer_q, timer_d;
    logic [KW-1:0]        cool_q, cool_d;
    logic [MOVE_BITS-1:0] pend_q, pend_d;
    logic [MOVE_BITS-1:0] code_q, code_d;
    logic [TOTAL-1:0]     shift_next;
    logic [MOVE_BITS-1:0] issue_code;

    assign shift_next = {shift_q[TOTAL-2:0], random_bit};

`ifdef ATTACK_GEN_NO_REPEAT_EN
    logic [MOVE_BITS-1:0] last_q, last_d;
    assign issue_code = (pend_q == last_q) ? pend_q + 1'b1 : pend_q;
`else
    assign issue_code = pend_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        timer_d = timer_q;
        cool_d  = cool_q;
        pend_d  = pend_q;
        code_d  = code_q;
`ifdef ATTACK_GEN_NO_REPEAT_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = GATHER;
                cnt_d   = '0;
            end
            GATHER: if (!start) state_d = IDLE;
            else begin
                shift_d = shift_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(TOTAL - 1)) begin
                    state_d = WAIT;
                    pend_d  = shift_next[TOTAL-1 -: MOVE_BITS];
                    timer_d = 8'(BASE_DELAY) + 8'(shift_next[DELAY_BITS-1:0]);
                end
            end
            WAIT: if (!start) state_d = IDLE;
            else if (stun) begin
                state_d = COOL;
                cool_d  = KW'(COOLDOWN);
            end else begin
                timer_d = timer_q - 8'd1;
                if (timer_q == 8'd1) begin
                    state_d = ISSUE;
                    code_d  = issue_code;
                end
            end
            // Once valid is up, only the handshake can leave ISSUE.
            ISSUE: if (bus.move_ready) begin
                state_d = COOL;
                cool_d  = KW'(COOLDOWN);
`ifdef ATTACK_GEN_NO_REPEAT_EN
                last_d  = code_q;
`endif
            end
            COOL: if (!start) state_d = IDLE;
            else begin
                cool_d = cool_q - 1'b1;
                if (cool_q == KW'(1)) begin
                    state_d = GATHER;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            timer_q <= '0;
            cool_q  <= '0;
            pend_q  <= '0;
            code_q  <= '0;
`ifdef ATTACK_GEN_NO_REPEAT_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            timer_q <= timer_d;
            cool_q  <= cool_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
`ifdef ATTACK_GEN_NO_REPEAT_EN
            last_q  <= last_d;
`endif
        end
    end

    assign lfsr_enable    = state_q == GATHER;
    assign telegraph      = state_q == WAIT;
    assign bus.move_valid = state_q == ISSUE;
    assign bus.move_code  = code_q;
endmodule

// File: tb/tb_opponent_attack_gen.sv
// tb_opponent_attack_gen: directed vectors for opponent_attack_gen with hand-computed expectations
module tb_opponent_attack_gen;
    logic clk = 1'b0;
    logic rst;
    logic start = 1'b0, random_bit = 1'b0, stun = 1'b0;
    logic lfsr_enable, telegraph;
    int vecs = 0, errs = 0;
    logic [1:0] last_m = 2'd0;

    opponent_attack_gen_if #(.MOVE_BITS(2)) bus();

    opponent_attack_gen dut (
        .clock(clk), .reset(rst), .start(start), .random_bit(random_bit), .stun(stun),
        .lfsr_enable(lfsr_enable), .telegraph(telegraph), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_code(input logic [1:0] g);
`ifdef ATTACK_GEN_NO_REPEAT_EN
        return (g == last_m) ? g + 2'd1 : g;
`else
        return g;
`endif
    endfunction

    // Runs one attack: feeds bits while lfsr_enable is up, holds ready low for hold valid cycles.
    task automatic attack(input string tag, input logic [5:0] bits, input int hold,
                          input int drop_at, input int exp_tel);
        int idx = 0, en_n = 0, tel_n = 0, val_n = 0;
        logic [1:0] code = 2'd0, first = 2'd0, exp;
        logic stable = 1'b1, done = 1'b0;
        start = 1'b1;
        bus.move_ready = (hold == 0);
        for (int c = 0; c < 400 && !done; c++) begin
            if (lfsr_enable) begin
                en_n++;
                if (idx < 6) begin
                    random_bit = bits[5-idx];
                    idx++;
                end
            end
            if (telegraph) tel_n++;
            if (bus.move_valid) begin
                val_n++;
                if (val_n == 1) first = bus.move_code;
                if (bus.move_code !== first) stable = 1'b0;
                code = bus.move_code;
                bus.move_ready = (val_n >= hold);
                if (val_n == drop_at) start = 1'b0;
            end else if (val_n > 0) done = 1'b1;
            if (!done) tick;
        end
        exp = model_code(bits[5:4]);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " lfsr_cycles"}, en_n, 6);
        check({tag, " telegraph_cycles"}, tel_n, exp_tel);
        check({tag, " valid_cycles"}, val_n, (hold == 0) ? 1 : hold);
        check({tag, " code"}, 32'(code), 32'(exp));
        check({tag, " code_stable"}, 32'(stable), 1);
        check({tag, " code_kept"}, 32'(bus.move_code), 32'(exp));
        last_m = exp;
        bus.move_ready = 1'b0;
    endtask

    initial begin
        int n, v;
        bit seen;
        logic [5:0] seq = 6'b100101;
        rst = 1'b1;
        bus.move_ready = 1'b0;
        #1;
        check("rst lfsr_enable", 32'(lfsr_enable), 0);
        check("rst telegraph", 32'(telegraph), 0);
        check("rst move_valid", 32'(bus.move_valid), 0);
        check("rst move_code", 32'(bus.move_code), 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("idle without start", 32'(lfsr_enable), 0);

        attack("basic", seq, 0, 0, 13);
        attack("hold", seq, 20, 5, 13);
        tick;
        check("idle after drop", 32'(lfsr_enable | telegraph), 0);

        start = 1'b1;
        tick;
        check("stun gather", 32'(lfsr_enable), 1);
        for (int i = 0; i < 6; i++) begin
            random_bit = seq[5-i];
            tick;
        end
        check("stun wait", 32'(telegraph), 1);
        tick;
        tick;
        stun = 1'b1;
        tick;
        stun = 1'b0;
        check("stun telegraph drop", 32'(telegraph), 0);
        n = 0;
        v = 0;
        while (!lfsr_enable && n < 100) begin
            if (bus.move_valid || telegraph) v++;
            n++;
            tick;
        end
        check("stun cool_cycles", n, 16);
        check("stun no_valid", v, 0);

        for (int i = 0; i < 3; i++) begin
            random_bit = 1'b1;
            tick;
        end
        start = 1'b0;
        tick;
        check("drop gather idle", 32'(lfsr_enable), 0);
        attack("restart", seq, 0, 0, 13);

        attack("repeat1", 6'b110000, 0, 0, 8);
        attack("repeat2", 6'b110000, 0, 0, 8);

        seen = 1'b0;
        random_bit = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (bus.move_valid) seen = 1'b1;
            else tick;
        end
        check("reset_issue reached", 32'(seen), 1);
        #3 rst = 1'b1;
        #1;
        check("async rst move_valid", 32'(bus.move_valid), 0);
        check("async rst move_code", 32'(bus.move_code), 0);
        check("async rst outs", 32'(lfsr_enable | telegraph), 0);
        tick;
        check("held rst idle", 32'(lfsr_enable | bus.move_valid), 0);
        rst = 1'b0;
        tick;
        check("gather after reset", 32'(lfsr_enable), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
